// File: rtl/bg_fetch_sequencer_if.sv
// Background fetch bus: nametable read port, shared CHR ROM
// request/grant port and ping-pong line-buffer write port.
interface bg_fetch_sequencer_if;
  logic [9:0]  nt_addr;
  logic [7:0]  nt_data;
  logic        chr_req;
  logic        chr_gnt;
  logic [12:0] chr_addr;
  logic [7:0]  chr_data;
  logic        lb_we;
  logic        lb_bank;
  logic [4:0]  lb_addr;
  logic [15:0] lb_data;

  modport master (
    output nt_addr,
    input  nt_data,
    output chr_req,
    input  chr_gnt,
    output chr_addr,
    input  chr_data,
    output lb_we,
    output lb_bank,
    output lb_addr,
    output lb_data
  );

  modport slave (
    input  nt_addr,
    output nt_data,
    input  chr_req,
    output chr_gnt,
    input  chr_addr,
    output chr_data,
    input  lb_we,
    input  lb_bank,
    input  lb_addr,
    input  lb_data
  );
endinterface

// File: rtl/bg_fetch_sequencer.sv
// Per-scanline NES background fetch: nametable byte, CHR lo/hi
// planes per tile, interleaved 2-bit pixels into a ping-pong buffer.
module bg_fetch_sequencer #(
  parameter int TILES_PER_LINE = 32,
  parameter int MAX_LINE       = 240
) (
  input  logic       CLOCK_24,
  input  logic       reset,
  input  logic       line_start,
  input  logic [7:0] line_num,
  input  logic       table_select,
  output logic       busy,
  output logic       line_done,
  output logic       overrun,
  bg_fetch_sequencer_if.master bus
);

  localparam logic [4:0] LAST_TILE  = 5'(TILES_PER_LINE - 1);
  localparam logic [8:0] LINE_LIMIT = 9'(MAX_LINE);

  typedef enum logic [3:0] {
    IDLE,
    NT_RD,
    NT_CAP,
    LO_REQ,
    LO_CAP,
    HI_REQ,
    HI_CAP,
    WRITE,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] tile_q, tile_d;
  logic [7:0] line_q, line_d;
  logic [7:0] tile_id_q, tile_id_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic       bank_q, bank_d;
  logic       overrun_q, overrun_d;
  logic [15:0] pix;

  // State and datapath registers; reset abandons any fetch in flight.
  always_ff @(posedge CLOCK_24 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tile_q    <= '0;
      line_q    <= '0;
      tile_id_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      bank_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tile_q    <= tile_d;
      line_q    <= line_d;
      tile_id_q <= tile_id_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      bank_q    <= bank_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic: one tile is NT read, two CHR reads, one write.
  always_comb begin
    state_d   = state_q;
    tile_d    = tile_q;
    line_d    = line_q;
    tile_id_d = tile_id_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    bank_d    = bank_q;
    overrun_d = overrun_q | (line_start & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (line_start && ({1'b0, line_num} < LINE_LIMIT)) begin
          line_d  = line_num;
          tile_d  = '0;
          bank_d  = ~bank_q;
          state_d = NT_RD;
        end
      end
      NT_RD:  state_d = NT_CAP;
      NT_CAP: begin
        tile_id_d = bus.nt_data;
        state_d   = LO_REQ;
      end
      LO_REQ: begin
        if (bus.chr_gnt) state_d = LO_CAP;
      end
      LO_CAP: begin
        lo_d    = bus.chr_data;
        state_d = HI_REQ;
      end
      HI_REQ: begin
        if (bus.chr_gnt) state_d = HI_CAP;
      end
      HI_CAP: begin
        hi_d    = bus.chr_data;
        state_d = WRITE;
      end
      WRITE: begin
        if (tile_q == LAST_TILE) begin
          state_d = DONE;
        end else begin
          tile_d  = tile_q + 5'd1;
          state_d = NT_RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel k (leftmost first) takes bit 7-k of each plane.
  always_comb begin
    pix = '0;
    for (int k = 0; k < 8; k++) begin
      pix[2*k]   = lo_q[7-k];
      pix[2*k+1] = hi_q[7-k];
    end
  end

  // Bus outputs are decoded from state so they drop to 0 on reset.
  always_comb begin
    busy         = (state_q != IDLE);
    line_done    = (state_q == DONE);
    overrun      = overrun_q;
    bus.nt_addr  = '0;
    bus.chr_req  = 1'b0;
    bus.chr_addr = '0;
    bus.lb_we    = 1'b0;
    bus.lb_bank  = bank_q;
    bus.lb_addr  = '0;
    bus.lb_data  = '0;
    unique case (state_q)
      NT_RD: bus.nt_addr = {line_q[7:3], tile_q};
      LO_REQ: begin
        bus.chr_req  = 1'b1;
        bus.chr_addr = {table_select, tile_id_q, 1'b0, line_q[2:0]};
      end
      HI_REQ: begin
        bus.chr_req  = 1'b1;
        bus.chr_addr = {table_select, tile_id_q, 1'b1, line_q[2:0]};
      end
      WRITE: begin
        bus.lb_we   = 1'b1;
        bus.lb_addr = tile_q;
        bus.lb_data = pix;
      end
      default: ;
    endcase
  end

endmodule
